// File: rtl/vend_seq_ctrl_if.sv
// Coin/select/dispense/refund signal bundle for vend_seq_ctrl.
// The master drives the buyer and mechanism inputs; the slave is the controller.
interface vend_seq_ctrl_if;
   logic       pi_money_one;
   logic       pi_money_half;
   logic       pi_select;
   logic       pi_cancel;
   logic       pi_disp_done;
   logic       pi_hopper_rdy;
   logic       po_dispense;
   logic       po_refund_half;
   logic       po_coin_reject;
   logic [3:0] po_credit;
   logic       po_busy;

   modport master (
      output pi_money_one, pi_money_half, pi_select, pi_cancel, pi_disp_done, pi_hopper_rdy,
      input  po_dispense, po_refund_half, po_coin_reject, po_credit, po_busy
   );

   modport slave (
      input  pi_money_one, pi_money_half, pi_select, pi_cancel, pi_disp_done, pi_hopper_rdy,
      output po_dispense, po_refund_half, po_coin_reject, po_credit, po_busy
   );
endinterface

// File: rtl/vend_seq_ctrl.sv
// Vending sequence controller: credit accounting, vend handshake and half-coin change refund.
// Optional idle-credit auto-refund is enabled by defining VEND_TIMEOUT_REFUND_EN.
module vend_seq_ctrl #(
   parameter int unsigned PRICE       = 3,
   parameter int unsigned MAX_CREDIT  = 7,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input logic            sys_clk,
   input logic            sys_rst_n,
   vend_seq_ctrl_if.slave bus
);

   if (PRICE < 1 || PRICE > MAX_CREDIT || MAX_CREDIT > 15 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("vend_seq_ctrl: illegal parameter combination");
   end

   localparam logic [3:0] PriceC = 4'(PRICE);
   localparam logic [4:0] MaxC   = 5'(MAX_CREDIT);

   typedef enum logic [1:0] {StIdle, StCredit, StVend, StRefund} state_e;

   state_e     state_q, state_d;
   logic [3:0] credit_q, credit_d;
   logic       dispense_q, dispense_d;
   logic       refund_q, refund_d;
   logic       reject_q, reject_d;
   logic       busy_q, busy_d;

   logic       coin_one, coin_half, coin_any, coin_ok, can_vend, activity, tmo_hit;
   logic [4:0] credit_sum;

   always_comb begin
      coin_one   = bus.pi_money_one & ~bus.pi_money_half;
      coin_half  = bus.pi_money_half & ~bus.pi_money_one;
      coin_any   = bus.pi_money_one | bus.pi_money_half;
      credit_sum = {1'b0, credit_q} + (coin_one ? 5'd2 : 5'd1);
      can_vend   = (state_q == StCredit) && bus.pi_select && (credit_q >= PriceC);
      // A coin arriving alongside a winning cancel or vend is bounced, not banked
      coin_ok    = ((state_q == StIdle) || (state_q == StCredit)) && (coin_one | coin_half) &&
                   (credit_sum <= MaxC) && !((state_q == StCredit) && bus.pi_cancel) && !can_vend;
      activity   = coin_ok | bus.pi_select | bus.pi_cancel;
   end

`ifdef VEND_TIMEOUT_REFUND_EN
   localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CntW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d   = '0;
      tmo_hit = 1'b0;
      if (state_q == StCredit && !activity) begin
         if (tmo_q == CntW'(TIMEOUT_CYC - 1)) begin
            tmo_hit = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      refund_d = 1'b0;
      reject_d = coin_any & ~coin_ok;
      unique case (state_q)
         StIdle, StCredit: begin
            if (state_q == StCredit && bus.pi_cancel) begin
               state_d = StRefund;
            end else if (can_vend) begin
               credit_d = credit_q - PriceC;
               state_d  = StVend;
            end else if (coin_ok) begin
               credit_d = credit_sum[3:0];
               state_d  = StCredit;
            end else if (tmo_hit) begin
               state_d = StRefund;
            end
         end
         StVend: begin
            if (bus.pi_disp_done) begin
               state_d = (credit_q != 4'd0) ? StRefund : StIdle;
            end
         end
         StRefund: begin
            if (credit_q == 4'd0) begin
               state_d = StIdle;
            end else if (bus.pi_hopper_rdy) begin
               refund_d = 1'b1;
               credit_d = credit_q - 4'd1;
               if (credit_q == 4'd1) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      dispense_d = (state_d == StVend);
      busy_d     = (state_d == StVend) || (state_d == StRefund);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         credit_q   <= 4'd0;
         dispense_q <= 1'b0;
         refund_q   <= 1'b0;
         reject_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         dispense_q <= dispense_d;
         refund_q   <= refund_d;
         reject_q   <= reject_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.po_dispense    = dispense_q;
   assign bus.po_refund_half = refund_q;
   assign bus.po_coin_reject = reject_q;
   assign bus.po_credit      = credit_q;
   assign bus.po_busy        = busy_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed bench for vend_seq_ctrl (PRICE 3, MAX_CREDIT 7); TIMEOUT_CYC 8 when
// VEND_TIMEOUT_REFUND_EN is defined.
module tb_vend_seq_ctrl;
   logic sys_clk;
   logic sys_rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   pulses;
   int   bad;
   logic rdy_prev;

   vend_seq_ctrl_if bus ();

`ifdef VEND_TIMEOUT_REFUND_EN
   vend_seq_ctrl #(.PRICE(3), .MAX_CREDIT(7), .TIMEOUT_CYC(8)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );
`else
   vend_seq_ctrl #(.PRICE(3), .MAX_CREDIT(7), .TIMEOUT_CYC(1000)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );
`endif

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock, settle, then drop the single-cycle pulse inputs.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      bus.pi_money_one  = 1'b0;
      bus.pi_money_half = 1'b0;
      bus.pi_select     = 1'b0;
      bus.pi_cancel     = 1'b0;
   endtask

   initial begin
      sys_rst_n         = 1'b0;
      bus.pi_money_one  = 1'b0;
      bus.pi_money_half = 1'b0;
      bus.pi_select     = 1'b0;
      bus.pi_cancel     = 1'b0;
      bus.pi_disp_done  = 1'b0;
      bus.pi_hopper_rdy = 1'b0;
      repeat (3) tick();
      chk("rst_credit", 32'(bus.po_credit), 0);
      chk("rst_busy", 32'(bus.po_busy), 0);
      chk("rst_dispense", 32'(bus.po_dispense), 0);
      chk("rst_refund", 32'(bus.po_refund_half), 0);
      chk("rst_reject", 32'(bus.po_coin_reject), 0);
      sys_rst_n = 1'b1;
      tick();

      // half, one, select, done two cycles later
      bus.pi_money_half = 1'b1; tick();
      chk("t1_credit_half", 32'(bus.po_credit), 1);
      bus.pi_money_one = 1'b1; tick();
      chk("t1_credit_one", 32'(bus.po_credit), 3);
      bus.pi_select = 1'b1; tick();
      chk("t1_credit_vend", 32'(bus.po_credit), 0);
      chk("t1_dispense", 32'(bus.po_dispense), 1);
      chk("t1_busy", 32'(bus.po_busy), 1);
      tick();
      chk("t1_dispense_hold", 32'(bus.po_dispense), 1);
      bus.pi_disp_done = 1'b1; tick(); bus.pi_disp_done = 1'b0;
      chk("t1_dispense_off", 32'(bus.po_dispense), 0);
      chk("t1_idle_busy", 32'(bus.po_busy), 0);
      tick();
      chk("t1_no_refund", 32'(bus.po_refund_half), 0);

      // one, one, select, done with hopper ready -> one change pulse
      bus.pi_money_one = 1'b1; tick();
      bus.pi_money_one = 1'b1; tick();
      chk("t2_credit4", 32'(bus.po_credit), 4);
      bus.pi_select = 1'b1; tick();
      chk("t2_credit1", 32'(bus.po_credit), 1);
      chk("t2_dispense", 32'(bus.po_dispense), 1);
      bus.pi_disp_done = 1'b1; bus.pi_hopper_rdy = 1'b1; tick(); bus.pi_disp_done = 1'b0;
      chk("t2_refund_state", 32'(bus.po_busy), 1);
      chk("t2_dispense_off", 32'(bus.po_dispense), 0);
      tick();
      chk("t2_refund_pulse", 32'(bus.po_refund_half), 1);
      chk("t2_credit0", 32'(bus.po_credit), 0);
      chk("t2_idle", 32'(bus.po_busy), 0);
      tick();
      chk("t2_pulse_once", 32'(bus.po_refund_half), 0);
      bus.pi_hopper_rdy = 1'b0;

      // overflow: fourth one-yuan coin bounced
      repeat (3) begin bus.pi_money_one = 1'b1; tick(); end
      chk("t3_credit6", 32'(bus.po_credit), 6);
      bus.pi_money_one = 1'b1; tick();
      chk("t3_reject", 32'(bus.po_coin_reject), 1);
      chk("t3_credit_held", 32'(bus.po_credit), 6);
      tick();
      chk("t3_reject_pulse", 32'(bus.po_coin_reject), 0);
      bus.pi_cancel = 1'b1; bus.pi_hopper_rdy = 1'b1; tick();
      chk("t3_cancel_busy", 32'(bus.po_busy), 1);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         pulses += int'(bus.po_refund_half);
      end
      chk("t3_refund_count", 32'(pulses), 6);
      chk("t3_credit0", 32'(bus.po_credit), 0);
      chk("t3_idle", 32'(bus.po_busy), 0);
      bus.pi_hopper_rdy = 1'b0;

      // cancel beats select; refunds only on hopper-ready cycles
      bus.pi_money_one = 1'b1; tick();
      bus.pi_cancel = 1'b1; bus.pi_select = 1'b1; tick();
      chk("t4_busy", 32'(bus.po_busy), 1);
      chk("t4_no_dispense", 32'(bus.po_dispense), 0);
      chk("t4_credit2", 32'(bus.po_credit), 2);
      pulses = 0;
      bad    = 0;
      for (int i = 0; i < 8; i++) begin
         bus.pi_hopper_rdy = (i % 2 == 1);
         rdy_prev          = bus.pi_hopper_rdy;
         tick();
         if (bus.po_refund_half) begin
            pulses++;
            if (!rdy_prev) bad++;
         end
      end
      bus.pi_hopper_rdy = 1'b0;
      chk("t4_pulses", 32'(pulses), 2);
      chk("t4_bad_pulses", 32'(bad), 0);
      chk("t4_credit0", 32'(bus.po_credit), 0);
      chk("t4_idle", 32'(bus.po_busy), 0);

      // both coins at once in IDLE; coin during VEND
      bus.pi_money_one = 1'b1; bus.pi_money_half = 1'b1; tick();
      chk("t5_both_reject", 32'(bus.po_coin_reject), 1);
      chk("t5_both_credit", 32'(bus.po_credit), 0);
      chk("t5_both_idle", 32'(bus.po_busy), 0);
      bus.pi_money_half = 1'b1; tick();
      bus.pi_money_one = 1'b1; tick();
      bus.pi_select = 1'b1; tick();
      bus.pi_money_half = 1'b1; tick();
      chk("t5_vend_reject", 32'(bus.po_coin_reject), 1);
      chk("t5_vend_credit", 32'(bus.po_credit), 0);
      chk("t5_vend_dispense", 32'(bus.po_dispense), 1);
      bus.pi_disp_done = 1'b1; tick(); bus.pi_disp_done = 1'b0;
      chk("t5_done_idle", 32'(bus.po_busy), 0);

      // reset while refunding discards pending credit
      bus.pi_money_one = 1'b1; tick();
      bus.pi_cancel = 1'b1; tick();
      chk("t6_pre_busy", 32'(bus.po_busy), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("t6_async_credit", 32'(bus.po_credit), 0);
      chk("t6_async_busy", 32'(bus.po_busy), 0);
      tick();
      sys_rst_n = 1'b1;
      bus.pi_hopper_rdy = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(bus.po_refund_half);
      end
      bus.pi_hopper_rdy = 1'b0;
      chk("t6_no_refund", 32'(pulses), 0);

      // idle credit: auto-refund when enabled, held otherwise
      bus.pi_money_half = 1'b1; tick();
      chk("t7_credit1", 32'(bus.po_credit), 1);
`ifdef VEND_TIMEOUT_REFUND_EN
      repeat (7) tick();
      chk("t7_not_yet", 32'(bus.po_busy), 0);
      tick();
      chk("t7_timeout_busy", 32'(bus.po_busy), 1);
      bus.pi_hopper_rdy = 1'b1; tick(); bus.pi_hopper_rdy = 1'b0;
      chk("t7_refund", 32'(bus.po_refund_half), 1);
      chk("t7_credit0", 32'(bus.po_credit), 0);
`else
      repeat (100) tick();
      chk("t7_held_credit", 32'(bus.po_credit), 1);
      chk("t7_held_busy", 32'(bus.po_busy), 0);
      bus.pi_select = 1'b1; tick();
      chk("t7_short_select", 32'(bus.po_dispense), 0);
      chk("t7_short_credit", 32'(bus.po_credit), 1);
      bus.pi_cancel = 1'b1; bus.pi_hopper_rdy = 1'b1; tick();
      chk("t7_cancel_busy", 32'(bus.po_busy), 1);
      tick(); bus.pi_hopper_rdy = 1'b0;
      chk("t7_refund", 32'(bus.po_refund_half), 1);
      chk("t7_credit0", 32'(bus.po_credit), 0);
`endif
      tick();
      chk("t7_final_idle", 32'(bus.po_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
